// File: rtl/dac_tx.sv
// -----------------------------------------------------------------------------
// dac_tx : serial transmitter for the DAC side of the analog path.
//
// Accepts 8-bit samples over a valid/ready handshake into a one-deep holding
// register, frames each one as {2'b00, sample, 6'b000000} and shifts it out
// MSB first on a divided serial clock with an active-low frame strobe.
//
// Parameters:
//   CLK_DIV  : osc_clk cycles per half-period of dac_sclk (>= 2)
//   GAP_BITS : idle dac_sclk periods with dac_sync high between frames (>= 1)
//
// Ports:
//   osc_clk      in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   sample_data  in   [7:0] sample to transmit
//   sample_valid in   sample_data is valid
//   sample_ready out  holding register empty
//   dac_sclk     out  serial clock, idles low, DAC samples on its rising edge
//   dac_sync     out  frame strobe, active low
//   dac_din      out  serial data, changes on dac_sclk falls or at frame start
//   busy         out  FSM not in IDLE
//   frame_done   out  one-cycle pulse at end of each frame
//
// Build option:
//   DAC_TX_REPEAT_EN : when defined, an empty holding register after the gap
//                      retransmits the last frame (refresh mode), once at
//                      least one frame has completed since reset.
// -----------------------------------------------------------------------------
module dac_tx #(
  parameter int CLK_DIV  = 64,
  parameter int GAP_BITS = 2
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic [7:0] sample_data,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       dac_sclk,
  output logic       dac_sync,
  output logic       dac_din,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam int GAP_LEN = 2 * GAP_BITS * CLK_DIV;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int GAP_W   = $clog2(GAP_LEN);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  state_t            state, next_state;
  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [3:0]        bit_cnt;
  logic              hold_full;
  logic [7:0]        hold_reg;
  logic [14:0]       shreg;       // remaining bits; frame[15] goes straight to dac_din
  logic [7:0]        load_sample;
  logic [15:0]       load_frame;
  logic              accept;
  logic              load;
  logic              gap_done;
  logic              repeat_ok;

`ifdef DAC_TX_REPEAT_EN
  logic       sent_any;
  logic [7:0] last_sample;

  assign repeat_ok   = sent_any;
  assign load_sample = hold_full ? hold_reg : last_sample;
`else
  assign repeat_ok   = 1'b0;
  assign load_sample = hold_reg;
`endif

  assign accept       = sample_valid && !hold_full;
  assign sample_ready = !hold_full;
  assign busy         = (state != IDLE);
  assign load         = (state == IDLE) && (hold_full || repeat_ok);
  assign load_frame   = {2'b00, load_sample, 6'b000000};
  assign gap_done     = (state == GAP) && (gap_cnt == GAP_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge osc_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (load) next_state = SHIFT;
      SHIFT:   if (div_cnt == DIV_LAST && dac_sclk && bit_cnt == 4'd15) next_state = GAP;
      GAP:     if (gap_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control registers and outputs.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      hold_full  <= 1'b0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      dac_sclk   <= 1'b0;
      dac_sync   <= 1'b1;
      dac_din    <= 1'b0;
      frame_done <= 1'b0;
`ifdef DAC_TX_REPEAT_EN
      sent_any   <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;

      // Accept and load are mutually exclusive: accept needs hold_full low.
      if (accept)                 hold_full <= 1'b1;
      else if (load && hold_full) hold_full <= 1'b0;

      unique case (state)
        IDLE: begin
          div_cnt  <= '0;
          gap_cnt  <= '0;
          dac_sclk <= 1'b0;
          if (load) begin
            dac_sync <= 1'b0;
            dac_din  <= load_frame[15];
            bit_cnt  <= '0;
          end else begin
            dac_sync <= 1'b1;
            dac_din  <= 1'b0;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            dac_sclk <= !dac_sclk;
            if (dac_sclk) begin
              // 1->0 transition: advance to the next bit or close the frame.
              if (bit_cnt == 4'd15) begin
                dac_sync   <= 1'b1;
                dac_din    <= 1'b0;
                frame_done <= 1'b1;
`ifdef DAC_TX_REPEAT_EN
                sent_any   <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                dac_din <= shreg[14];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          dac_sclk <= 1'b0;
          gap_cnt  <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: pure data registers carry no reset; hold_full and the FSM decide
  // when their contents are meaningful, so stale values are never observed.
  always_ff @(posedge osc_clk) begin
    if (accept) hold_reg <= sample_data;
    if (load)
      shreg <= load_frame[14:0];
    else if (state == SHIFT && div_cnt == DIV_LAST && dac_sclk)
      shreg <= {shreg[13:0], 1'b0};
`ifdef DAC_TX_REPEAT_EN
    if (load) last_sample <= load_sample;
`endif
  end

endmodule

// File: tb/tb_dac_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_tx : self-checking bench for dac_tx (CLK_DIV=4, GAP_BITS=2).
// A frame-level model predicts every output from the cycle offset since the
// frame started; a monitor reassembles serial words for literal checks.
// -----------------------------------------------------------------------------
module tb_dac_tx;

  localparam int D       = 4;
  localparam int G       = 2;
  localparam int LOW     = 32 * D;            // cycles with dac_sync low
  localparam int LAST_PH = LOW + 2 * G * D;   // offset at which the FSM is idle again
  localparam int PERIOD  = LAST_PH + 1;       // back-to-back frame period
`ifdef DAC_TX_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       osc_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_data = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready, dac_sclk, dac_sync, dac_din, busy, frame_done;

  dac_tx #(.CLK_DIV(D), .GAP_BITS(G)) dut (
    .osc_clk      (osc_clk),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_sclk     (dac_sclk),
    .dac_sync     (dac_sync),
    .dac_din      (dac_din),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 osc_clk = ~osc_clk;

  int     n_vec  = 0;
  int     n_miss = 0;
  longint cyc    = 0;
  bit     armed  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_phase = -1;  // cycles since frame start, -1 when idle
  bit       m_hold_full = 1'b0;
  bit [7:0] m_hold = '0;
  bit [15:0] m_word = '0;
  bit       m_sent = 1'b0;

  always @(posedge osc_clk) begin
    cyc++;
    if (reset) begin
      armed       = 1'b1;
      m_phase     = -1;
      m_hold_full = 1'b0;
      m_sent      = 1'b0;
    end else begin
      bit acc;
      acc = sample_valid && !m_hold_full;
      if (m_phase < 0) begin
        if (m_hold_full) begin
          m_word      = {2'b00, m_hold, 6'b000000};
          m_hold_full = 1'b0;
          m_phase     = 0;
        end else if (REPEAT && m_sent) begin
          m_phase = 0;
        end
      end else begin
        m_phase++;
        if (m_phase == LOW) m_sent = 1'b1;
        if (m_phase == LAST_PH) m_phase = -1;
      end
      if (acc) begin
        m_hold_full = 1'b1;
        m_hold      = sample_data;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge osc_clk) begin
    if (armed) begin
      bit e_sync, e_sclk, e_din, e_busy, e_fd;
      e_sync = 1'b1; e_sclk = 1'b0; e_din = 1'b0; e_busy = 1'b0; e_fd = 1'b0;
      if (m_phase >= 0 && m_phase < LOW) begin
        e_sync = 1'b0;
        e_sclk = ((m_phase / D) % 2) == 1;
        e_din  = m_word[15 - m_phase / (2 * D)];
        e_busy = 1'b1;
      end else if (m_phase >= LOW) begin
        e_busy = 1'b1;
        e_fd   = (m_phase == LOW);
      end
      check("sync",  32'(dac_sync),     32'(e_sync));
      check("sclk",  32'(dac_sclk),     32'(e_sclk));
      check("din",   32'(dac_din),      32'(e_din));
      check("busy",  32'(busy),         32'(e_busy));
      check("fdone", 32'(frame_done),   32'(e_fd));
      check("ready", 32'(sample_ready), 32'(!m_hold_full));
    end
  end

  // ---------------- serial monitor ----------------
  logic        prev_sync = 1'b1, prev_sclk = 1'b0;
  logic [15:0] cur_word = '0;
  int          low_cnt = 0;
  int          fd_cnt = 0;
  logic [15:0] words[$];
  int          low_lens[$];
  longint      fall_t[$], rise_t[$];

  always @(negedge osc_clk) begin
    if (armed) begin
      if (!dac_sync && prev_sync) begin
        fall_t.push_back(cyc);
        cur_word = '0;
        low_cnt  = 0;
      end
      if (!dac_sync) begin
        low_cnt++;
        if (dac_sclk && !prev_sclk) cur_word = {cur_word[14:0], dac_din};
      end
      if (dac_sync && !prev_sync) begin
        rise_t.push_back(cyc);
        words.push_back(cur_word);
        low_lens.push_back(low_cnt);
      end
      if (frame_done) fd_cnt++;
      prev_sync = dac_sync;
      prev_sclk = dac_sclk;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_mon();
    words.delete(); low_lens.delete(); fall_t.delete(); rise_t.delete();
    fd_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge osc_clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge osc_clk);
    reset = 1'b0;
    #1;
    clear_mon();
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    @(negedge osc_clk);
    sample_valid = 1'b1;
    sample_data  = d;
    n = 0;
    while (!sample_ready && n < 2000) begin
      @(negedge osc_clk);
      n++;
    end
    check("send_ready", 32'(sample_ready), 32'd1);
    @(negedge osc_clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while ((fd_cnt < target || busy) && n < 5000) begin
      @(negedge osc_clk);
      n++;
    end
    #1;
    check("frame_count", 32'(fd_cnt), 32'(target));
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge osc_clk);
      n++;
    end
    check("went_busy", 32'(busy), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   n;
    int   rises;
    logic ps, pk;

    repeat (3) @(negedge osc_clk);
    check("rst_sync",  32'(dac_sync),     32'd1);
    check("rst_sclk",  32'(dac_sclk),     32'd0);
    check("rst_din",   32'(dac_din),      32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_fdone", 32'(frame_done),   32'd0);
    reset = 1'b0;
    #1;
    clear_mon();

    // Single sample 0xB5.
    send(8'hB5);
    wait_frames(1);
    check("b5_nwords", 32'(words.size()), 32'd1);
    check("b5_word",   32'(words[0]),     32'h2D40);
    check("b5_low",    32'(low_lens[0]),  32'(LOW));
    apply_reset();

    // 0x00 then 0xFF queued while the first frame shifts.
    send(8'h00);
    wait_busy();
    send(8'hFF);
    wait_frames(2);
    check("b2b_word0", 32'(words[0]), 32'h0000);
    check("b2b_word1", 32'(words[1]), 32'h3FC0);
    check("b2b_gap",   32'(fall_t[1] - rise_t[0]), 32'(2 * G * D + 1));
    check("b2b_low1",  32'(low_lens[1]), 32'(LOW));
    apply_reset();

    // Buffer full: valid held, ready low, no accept until the next load.
    send(8'h11);
    wait_busy();
    send(8'h22);
    sample_valid = 1'b1;
    sample_data  = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge osc_clk);
      check("full_ready_low", 32'(sample_ready), 32'd0);
    end
    n  = 0;
    ps = dac_sync;
    while (!sample_ready && n < 2000) begin
      ps = dac_sync;
      @(negedge osc_clk);
      n++;
    end
    check("ready_with_load", 32'({ps, dac_sync}), 32'b10);
    @(negedge osc_clk);
    sample_valid = 1'b0;
    wait_frames(3);
    check("full_w0", 32'(words[0]), 32'h0440);
    check("full_w1", 32'(words[1]), 32'h0880);
    check("full_w2", 32'(words[2]), 32'h0CC0);
    apply_reset();

    // Reset in the middle of a frame (after bit 7 has been sampled).
    send(8'hA7);
    rises = 0;
    n     = 0;
    pk    = dac_sclk;
    while (rises < 8 && n < 1000) begin
      @(negedge osc_clk);
      if (dac_sclk && !pk) rises++;
      pk = dac_sclk;
      n++;
    end
    check("mid_rises", 32'(rises), 32'd8);
    reset = 1'b1;
    @(negedge osc_clk);
    check("mid_rst_sync",  32'(dac_sync),     32'd1);
    check("mid_rst_sclk",  32'(dac_sclk),     32'd0);
    check("mid_rst_ready", 32'(sample_ready), 32'd1);
    check("mid_rst_fdone", 32'(frame_done),   32'd0);
    reset = 1'b0;
    #1;
    check("mid_no_fdone", 32'(fd_cnt), 32'd0);
    clear_mon();
    send(8'h3C);
    wait_frames(1);
    check("mid_clean_word", 32'(words[0]),    32'h0F00);
    check("mid_clean_low",  32'(low_lens[0]), 32'(LOW));
    apply_reset();

    // Idle behaviour after one frame of 0x5A.
    send(8'h5A);
    repeat (3 * PERIOD + 50) @(negedge osc_clk);
    #1;
    check("idle_word0", 32'(words[0]), 32'h1680);
`ifdef DAC_TX_REPEAT_EN
    check("idle_repeats", 32'(fall_t.size() >= 3), 32'd1);
    check("idle_period",  32'(fall_t[1] - fall_t[0]), 32'(PERIOD));
    check("idle_word1",   32'(words[1]), 32'h1680);
    check("idle_fdones",  32'(fd_cnt >= 2), 32'd1);
`else
    check("idle_one_frame", 32'(fall_t.size()), 32'd1);
    check("idle_sync_high", 32'(dac_sync), 32'd1);
    check("idle_fdones",    32'(fd_cnt), 32'd1);
`endif
    apply_reset();

    // Randomised traffic against the per-cycle model.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 150)) @(negedge osc_clk);
      send(8'($urandom));
    end
    repeat (2 * PERIOD + 10) @(negedge osc_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
